// File: rtl/branch_rs_queue_if.sv
// Port bundle for the branch reservation station: issue port, CDB snoop bus,
// flush, and the registered result port toward the CDB arbiter.
interface branch_rs_queue_if #(
    parameter int WORD_SIZE = 16,
    parameter int RB_INDEX  = 3,
    parameter int RB_SIZE   = 8,
    parameter int DEPTH     = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    // Valid/ready: a transfer happens on a rising edge where valid && ready are both 1;
    // the producer holds its payload steady while valid=1 and ready=0.
    logic                          flush;
    logic                          issue_valid;
    logic                          issue_ready;
    logic [RB_INDEX-1:0]           issue_dest;
    logic [1:0]                    issue_cond;
    logic [WORD_SIZE-1:0]          issue_vj;
    logic [WORD_SIZE-1:0]          issue_vk;
    logic [RB_INDEX-1:0]           issue_qj;
    logic [RB_INDEX-1:0]           issue_qk;
    logic                          issue_rdyj;
    logic                          issue_rdyk;
    logic [WORD_SIZE*RB_SIZE-1:0]  cdb_data;
    logic [RB_SIZE-1:0]            cdb_valid;
    logic                          res_valid;
    logic                          res_ready;
    logic                          res_taken;
    logic [RB_INDEX-1:0]           res_dest;
    logic [CW-1:0]                 count;

    modport master (
        output flush, issue_valid, issue_dest, issue_cond, issue_vj, issue_vk,
               issue_qj, issue_qk, issue_rdyj, issue_rdyk, cdb_data, cdb_valid, res_ready,
        input  issue_ready, res_valid, res_taken, res_dest, count
    );

    modport slave (
        input  flush, issue_valid, issue_dest, issue_cond, issue_vj, issue_vk,
               issue_qj, issue_qk, issue_rdyj, issue_rdyk, cdb_data, cdb_valid, res_ready,
        output issue_ready, res_valid, res_taken, res_dest, count
    );
endinterface

// File: rtl/branch_rs_queue.sv
// Multi-entry branch reservation station: collapsing age-ordered queue with CDB
// operand wake-up, oldest-ready select, signed condition evaluation and a result register.
module branch_rs_queue #(
    parameter int WORD_SIZE = 16,
    parameter int RB_INDEX  = 3,
    parameter int RB_SIZE   = 8,
    parameter int DEPTH     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    branch_rs_queue_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic                 valid;
        logic [RB_INDEX-1:0]  dest;
        logic [1:0]           cond;
        logic [WORD_SIZE-1:0] vj;
        logic [RB_INDEX-1:0]  qj;
        logic                 rj;
        logic [WORD_SIZE-1:0] vk;
        logic [RB_INDEX-1:0]  qk;
        logic                 rk;
    } entry_t;

    entry_t              q_r    [DEPTH];
    entry_t              q_woke [DEPTH];
    entry_t              q_nxt  [DEPTH];
    entry_t              new_e;
    entry_t              sel_e;
    logic [CW-1:0]       count_r;
    logic [CW-1:0]       ins_idx;
    logic [IW-1:0]       sel_idx;
    logic                sel_found;
    logic                dispatch;
    logic                do_issue;
    logic                sel_taken;
    logic                res_valid_r;
    logic                res_taken_r;
    logic [RB_INDEX-1:0] res_dest_r;

    // Tags at or above RB_SIZE never match, so no out-of-range CDB lane is read.
    function automatic logic cdb_hit(input logic [RB_INDEX-1:0] tag,
                                     input logic [RB_SIZE-1:0] valid_vec);
        logic hit;
        hit = 1'b0;
        for (int t = 0; t < RB_SIZE; t++)
            if (tag == RB_INDEX'(t)) hit = valid_vec[t];
        return hit;
    endfunction

    function automatic logic [WORD_SIZE-1:0] cdb_word(input logic [RB_INDEX-1:0] tag,
                                                      input logic [WORD_SIZE*RB_SIZE-1:0] data_vec);
        logic [WORD_SIZE-1:0] w;
        w = '0;
        for (int t = 0; t < RB_SIZE; t++)
            if (tag == RB_INDEX'(t)) w = data_vec[t*WORD_SIZE +: WORD_SIZE];
        return w;
    endfunction

    assign do_issue = bus.issue_valid && bus.issue_ready;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        // Scan youngest to oldest so the oldest ready entry wins the last assignment.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (q_r[i].valid && q_r[i].rj && q_r[i].rk) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
        sel_e    = q_r[sel_idx];
        dispatch = sel_found && (!res_valid_r || bus.res_ready);
        unique case (sel_e.cond)
            2'b00:   sel_taken = $signed(sel_e.vj) >= $signed(sel_e.vk);
            2'b01:   sel_taken = $signed(sel_e.vj) <  $signed(sel_e.vk);
            2'b10:   sel_taken = sel_e.vj == sel_e.vk;
            default: sel_taken = sel_e.vj != sel_e.vk;
        endcase
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_woke[i] = q_r[i];
            if (!q_r[i].rj && cdb_hit(q_r[i].qj, bus.cdb_valid)) begin
                q_woke[i].vj = cdb_word(q_r[i].qj, bus.cdb_data);
                q_woke[i].rj = 1'b1;
            end
            if (!q_r[i].rk && cdb_hit(q_r[i].qk, bus.cdb_valid)) begin
                q_woke[i].vk = cdb_word(q_r[i].qk, bus.cdb_data);
                q_woke[i].rk = 1'b1;
            end
        end

        new_e.valid = 1'b1;
        new_e.dest  = bus.issue_dest;
        new_e.cond  = bus.issue_cond;
        new_e.vj    = bus.issue_vj;
        new_e.qj    = bus.issue_qj;
        new_e.rj    = bus.issue_rdyj;
        new_e.vk    = bus.issue_vk;
        new_e.qk    = bus.issue_qk;
        new_e.rk    = bus.issue_rdyk;
        if (!bus.issue_rdyj && cdb_hit(bus.issue_qj, bus.cdb_valid)) begin
            new_e.vj = cdb_word(bus.issue_qj, bus.cdb_data);
            new_e.rj = 1'b1;
        end
        if (!bus.issue_rdyk && cdb_hit(bus.issue_qk, bus.cdb_valid)) begin
            new_e.vk = cdb_word(bus.issue_qk, bus.cdb_data);
            new_e.rk = 1'b1;
        end

        for (int i = 0; i < DEPTH; i++) q_nxt[i] = q_woke[i];
        // Removing the dispatched entry slides every younger entry down one slot.
        if (dispatch) begin
            for (int i = 0; i < DEPTH - 1; i++)
                if (IW'(i) >= sel_idx) q_nxt[i] = q_woke[i+1];
            q_nxt[DEPTH-1] = '0;
        end
        ins_idx = count_r - CW'(dispatch);
        if (do_issue) begin
            for (int i = 0; i < DEPTH; i++)
                if (CW'(i) == ins_idx) q_nxt[i] = new_e;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) q_r[i] <= '0;
            count_r     <= '0;
            res_valid_r <= 1'b0;
            res_taken_r <= 1'b0;
            res_dest_r  <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) q_r[i] <= '0;
            count_r     <= '0;
            res_valid_r <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q_r[i] <= q_nxt[i];
            count_r <= count_r + CW'(do_issue) - CW'(dispatch);
            if (dispatch) begin
                res_valid_r <= 1'b1;
                res_taken_r <= sel_taken;
                res_dest_r  <= sel_e.dest;
            end else if (res_valid_r && bus.res_ready) begin
                res_valid_r <= 1'b0;
            end
        end
    end

    assign bus.issue_ready = count_r < CW'(DEPTH);
    assign bus.count       = count_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.res_taken   = res_taken_r;
    assign bus.res_dest    = res_dest_r;
endmodule

// File: tb/tb_branch_rs_queue.sv
// Directed bench for branch_rs_queue: results are checked against an expected
// queue of {taken, dest} pushed as branches are issued.
module tb_branch_rs_queue;
    localparam int W  = 16;
    localparam int RI = 3;
    localparam int RS = 8;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    branch_rs_queue_if #(.WORD_SIZE(W), .RB_INDEX(RI), .RB_SIZE(RS), .DEPTH(D)) bus ();
    branch_rs_queue #(.WORD_SIZE(W), .RB_INDEX(RI), .RB_SIZE(RS), .DEPTH(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [RI:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_taken(input logic [1:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        case (c)
            2'b00:   return $signed(a) >= $signed(b);
            2'b01:   return $signed(a) <  $signed(b);
            2'b10:   return a == b;
            default: return a != b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [RI-1:0] dest, input logic [1:0] cond,
                         input logic [W-1:0] vj, input logic [W-1:0] vk,
                         input logic [RI-1:0] qj, input logic [RI-1:0] qk,
                         input logic rj, input logic rk);
        bus.issue_dest  = dest;
        bus.issue_cond  = cond;
        bus.issue_vj    = vj;
        bus.issue_vk    = vk;
        bus.issue_qj    = qj;
        bus.issue_qk    = qk;
        bus.issue_rdyj  = rj;
        bus.issue_rdyk  = rk;
        bus.issue_valid = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check("drain_left", exp_q.size(), 0);
    endtask

    // Result port monitor: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && !bus.flush && bus.res_valid && bus.res_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_result observed=%0h expected=none",
                       {bus.res_taken, bus.res_dest});
            end
            if (exp_q.size() != 0) begin
                logic [RI:0] e;
                e = exp_q.pop_front();
                check("result", 32'({bus.res_taken, bus.res_dest}), 32'(e));
            end
        end
    end

    initial begin
        logic [W-1:0] a, b;
        bus.flush = 0; bus.issue_valid = 0; bus.issue_dest = 0; bus.issue_cond = 0;
        bus.issue_vj = 0; bus.issue_vk = 0; bus.issue_qj = 0; bus.issue_qk = 0;
        bus.issue_rdyj = 0; bus.issue_rdyk = 0; bus.cdb_data = '0; bus.cdb_valid = '0;
        bus.res_ready = 0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_taken", bus.res_taken, 0);
        check("rst_res_dest", bus.res_dest, 0);
        check("rst_count", bus.count, 0);
        check("rst_issue_ready", bus.issue_ready, 1);

        // Ready issue: two-edge latency, then handshake clears the register.
        bus.res_ready = 1;
        exp_q.push_back({1'b1, 3'd3});
        issue(3'd3, 2'b00, 16'd5, 16'd5, 3'd0, 3'd0, 1, 1);
        check("lat_count", bus.count, 1);
        check("lat_valid_early", bus.res_valid, 0);
        tick();
        check("lat_valid", bus.res_valid, 1);
        check("lat_dest", bus.res_dest, 3);
        check("lat_taken", bus.res_taken, 1);
        tick();
        check("lat_valid_clear", bus.res_valid, 0);

        // Signed compares, back to back.
        exp_q.push_back({1'b1, 3'd0});
        issue(3'd0, 2'b01, 16'hFFFF, 16'd1, 3'd0, 3'd0, 1, 1);
        exp_q.push_back({1'b0, 3'd1});
        issue(3'd1, 2'b00, 16'hFFFF, 16'd1, 3'd0, 3'd0, 1, 1);
        exp_q.push_back({1'b1, 3'd2});
        issue(3'd2, 2'b10, 16'd7, 16'd7, 3'd0, 3'd0, 1, 1);
        exp_q.push_back({1'b0, 3'd3});
        issue(3'd3, 2'b11, 16'd7, 16'd7, 3'd0, 3'd0, 1, 1);
        drain();

        // Wake-up ordering: B (ready) overtakes older A waiting on tag 2.
        exp_q.push_back({1'b1, 3'd6});
        exp_q.push_back({1'b1, 3'd5});
        issue(3'd5, 2'b10, 16'd0, 16'd9, 3'd2, 3'd0, 0, 1);
        issue(3'd6, 2'b11, 16'd1, 16'd2, 3'd0, 3'd0, 1, 1);
        bus.cdb_valid = 8'b0000_0100;
        bus.cdb_data[2*W +: W] = 16'd9;
        tick();
        bus.cdb_valid = '0;
        bus.cdb_data  = '0;
        check("wake_count", bus.count, 1);
        check("wake_first_dest", bus.res_dest, 6);
        tick();
        check("wake_second_dest", bus.res_dest, 5);
        check("wake_second_taken", bus.res_taken, 1);
        drain();

        // Operand broadcast in the same cycle as issue is captured.
        exp_q.push_back({1'b1, 3'd4});
        bus.cdb_valid = 8'b0000_0100;
        bus.cdb_data[2*W +: W] = 16'd9;
        issue(3'd4, 2'b10, 16'd0, 16'd9, 3'd2, 3'd0, 0, 1);
        bus.cdb_valid = '0;
        bus.cdb_data  = '0;
        drain();

        // Full and back-pressure: one result held, four entries queued.
        bus.res_ready = 0;
        for (int k = 0; k < 5; k++) begin
            a = 16'($urandom_range(0, 65535));
            b = (k == 2) ? a : 16'($urandom_range(0, 65535));
            exp_q.push_back({model_taken(2'(k), a, b), 3'(k)});
            issue(3'(k), 2'(k), a, b, 3'd0, 3'd0, 1, 1);
        end
        check("full_count", bus.count, 4);
        check("full_issue_ready", bus.issue_ready, 0);
        check("full_res_valid", bus.res_valid, 1);
        check("full_res_dest", bus.res_dest, 0);
        issue(3'd7, 2'b00, 16'd1, 16'd1, 3'd0, 3'd0, 1, 1);
        check("full_ignored_count", bus.count, 4);
        check("held_res_dest", bus.res_dest, 0);
        bus.res_ready = 1;
        drain();
        check("drained_issue_ready", bus.issue_ready, 1);
        check("drained_count", bus.count, 0);

        // Flush discards pending entries and the held result.
        bus.res_ready = 0;
        for (int k = 0; k < 4; k++) issue(3'(k), 2'b00, 16'd1, 16'd2, 3'd0, 3'd0, 1, 1);
        check("preflush_count", bus.count, 3);
        check("preflush_valid", bus.res_valid, 1);
        bus.flush = 1;
        tick();
        bus.flush = 0;
        check("flush_count", bus.count, 0);
        check("flush_valid", bus.res_valid, 0);
        bus.res_ready = 1;
        exp_q.push_back({1'b0, 3'd2});
        issue(3'd2, 2'b01, 16'd4, 16'hFFFE, 3'd0, 3'd0, 1, 1);
        drain();

        // Asynchronous reset mid-cycle with work in flight.
        bus.res_ready = 0;
        issue(3'd5, 2'b00, 16'd5, 16'd5, 3'd0, 3'd0, 1, 1);
        issue(3'd1, 2'b00, 16'd5, 16'd5, 3'd0, 3'd0, 1, 1);
        issue(3'd2, 2'b00, 16'd5, 16'd5, 3'd0, 3'd0, 1, 1);
        check("prerst_count", bus.count, 2);
        check("prerst_dest", bus.res_dest, 5);
        #3 reset_n = 1'b0;
        #1;
        check("arst_res_valid", bus.res_valid, 0);
        check("arst_res_taken", bus.res_taken, 0);
        check("arst_res_dest", bus.res_dest, 0);
        check("arst_count", bus.count, 0);
        check("arst_issue_ready", bus.issue_ready, 1);
        tick();
        reset_n = 1'b1;
        bus.res_ready = 1;
        exp_q.push_back({1'b1, 3'd7});
        issue(3'd7, 2'b11, 16'd3, 16'd4, 3'd0, 3'd0, 1, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_rs_queue.md
# branch_rs_queue

Multi-entry, parametrised branch reservation station for the Tomasulo core: a generalisation of the single-slot branch station with a configurable entry count, four compare modes, and tag wake-up on both operands. It accepts branch micro-ops from the issue stage and snoops the per-ROB-entry CDB data/valid buses to capture pending operands. It selects the oldest entry whose operands are both ready, evaluates the condition, and presents the taken/not-taken result plus its reorder-buffer index on a registered valid/ready output port toward the CDB arbiter.

## Interface
- WORD_SIZE, 16, operand width
- RB_INDEX, 3, reorder-buffer tag width
- RB_SIZE, 8, number of ROB entries snooped on the CDB (≤ 2^RB_INDEX)
- DEPTH, 4, number of station entries (2..16)
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries and the output register (mispredict recovery)
- issue_valid  in  1  issue request this cycle
- issue_ready  out  1  station has a free entry (count < DEPTH); depends on state only
- issue_dest  in  RB_INDEX  ROB index the result is written to
- issue_cond  in  2  00 GE, 01 LT, 10 EQ, 11 NE (signed compare of Vj against Vk)
- issue_vj, issue_vk  in  WORD_SIZE  operand values, meaningful when the matching rdy bit is 1
- issue_qj, issue_qk  in  RB_INDEX  producer tags, meaningful when the matching rdy bit is 0
- issue_rdyj, issue_rdyk  in  1  operand already available
- cdb_data  in  WORD_SIZE*RB_SIZE  value for ROB entry i at bits [i*WORD_SIZE +: WORD_SIZE]
- cdb_valid  in  RB_SIZE  bit i set: ROB entry i is broadcasting this cycle
- res_valid  out  1  result register holds a result
- res_ready  in  1  consumer accepts the result this cycle
- res_taken  out  1  condition outcome
- res_dest  out  RB_INDEX  ROB index of the result
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Entry fields: valid, dest, cond, Vj, Qj, Rj, Vk, Qk, Rk, plus age ordering. Entries are kept in a collapsing queue: slot 0 is the oldest, and removal shifts the younger entries down.
- Issue (issue_valid && issue_ready): a new entry is written at slot count (after any same-cycle collapse). For each operand with rdy=0, if cdb_valid[q] is set in the same cycle, the entry captures cdb_data for q and is written as ready.
- Wake-up: each cycle, every valid entry with Rx=0 and cdb_valid[Qx]=1 loads Vx from the CDB and sets Rx=1.
- Select: the lowest-index (oldest) entry with Rj && Rk is chosen, using state at the start of the cycle only; there is no CDB-to-select bypass. Dispatch happens when an entry is selected and (!res_valid || res_ready).
- On dispatch: res_taken is loaded with the result of cond (GE: $signed(Vj) >= $signed(Vk); LT: <; EQ: ==; NE: !=), res_dest <= dest, res_valid <= 1, and the entry is removed.
- Output handshake: if res_valid && res_ready and there is no dispatch, res_valid <= 0. res_taken and res_dest hold steady while res_valid=1 && res_ready=0.
- Issue, dispatch and wake-up may all occur in one cycle. count = count + issue − dispatch.
- flush takes priority over issue, dispatch and wake-up: all entries become invalid, res_valid <= 0, count <= 0.
- Reset (reset_n=0, asynchronous): all entry valid bits cleared, res_valid=0, res_taken=0, res_dest=0, count=0, issue_ready=1 on release. Reset mid-operation discards everything in flight.

## Timing
- Issue with both operands ready at edge E0 → entry eligible during cycle E0→E1 → res_valid=1 after E1. Minimum latency is 2 edges.
- CDB broadcast at edge Ew → operand ready after Ew → dispatch at Ew+1 at the earliest.
- Back-to-back: with res_ready held at 1, one result per cycle.
- Full: issue_ready=0 when count=DEPTH, even if a dispatch occurs in the same cycle. An issue request while issue_ready=0 is ignored.
- Back-pressure: while res_valid=1 && res_ready=0, no dispatch occurs and entries keep waking up.

## Test plan
- Ready issue: reset, then issue dest=3, GE, Vj=5, Vk=5, both rdy → two edges later res_valid=1, res_taken=1, res_dest=3; with res_ready=1, res_valid=0 on the next edge.
- Signed compare: LT with Vj=16'hFFFF, Vk=1 → taken=1. GE with the same operands → taken=0. EQ/NE with 7,7 → 1/0.
- Wake-up ordering: issue A (qj=2, not ready), then B (both ready), then broadcast cdb_valid[2] with data 9 → B dispatches first, A one cycle later with Vj=9. A issued in the same cycle as the broadcast of tag 2 is captured ready.
- Full and back-pressure: fill DEPTH=4 entries with res_ready=0 → count=4, issue_ready=0, only one result held in the register; raise res_ready → results drain in age order at one per cycle and issue_ready returns to 1.
- Flush: three entries pending and res_valid=1, assert flush → next edge count=0, res_valid=0; issue on the following cycle works normally.
- Async reset: drop reset_n mid-cycle while entries are pending → outputs clear immediately, without waiting for clk.
